inst_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the dual-issue instruction FIFO.
- Owns the fetch PC and issues 64-bit aligned requests to the I-cache, up to MAX_OUTSTANDING in flight.
- Buffers returned instruction pairs in a small response queue and drains them into the FIFO write port, one or two instructions per cycle, honouring fifo_full.
- On redirect (branch/exception/eret) it restarts at the new PC and discards stale in-flight responses.

---
 rtl/inst_fetch_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
//   Fetch stage in front of the dual-issue instruction FIFO. Owns the fetch PC,
//   keeps up to MAX_OUTSTANDING aligned 64-bit I-cache requests in flight,
//   buffers responses in a small queue and drains one pair (or one single
//   instruction) per cycle into the FIFO. A redirect restarts fetch at a new
//   PC and silently discards every response that was already in flight.
//   Optional performance counters are compiled in with `define FETCH_PERF_CNT_EN.
module inst_fetch_unit #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fifo_full,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_addr_ok,
    input  logic        icache_rvalid,
    input  logic [63:0] icache_rdata,
    input  logic        icache_rerr,
    output logic        write_en_1,
    output logic        write_en_2,
    output logic [31:0] write_inst1,
    output logic [31:0] write_inst2,
    output logic [31:0] write_pc1,
    output logic [31:0] write_pc2,
    output logic [13:0] write_inst_exp1
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_inst_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    // Counter width holds 0..MAX_OUTSTANDING, pointer width indexes the slots
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;

    // Per-request record (fetch PC and pair/single kind), in issue order
    logic [31:0]   r_rk_pc   [MAX_OUTSTANDING];
    logic          r_rk_pair [MAX_OUTSTANDING];
    logic [AW-1:0] r_rk_wr;
    logic [AW-1:0] r_rk_rd;

    // Response queue: instructions already selected from the 64-bit beat
    logic [31:0]   r_q_pc    [MAX_OUTSTANDING];
    logic [31:0]   r_q_inst1 [MAX_OUTSTANDING];
    logic [31:0]   r_q_inst2 [MAX_OUTSTANDING];
    logic          r_q_err   [MAX_OUTSTANDING];
    logic          r_q_pair  [MAX_OUTSTANDING];
    logic [AW-1:0] r_q_wr;
    logic [AW-1:0] r_q_rd;
    logic [CW-1:0] r_q_cnt;

    logic [CW:0]   w_in_flight;
    logic          w_req;
    logic          w_accept;
    logic          w_rsp_keep;
    logic          w_rsp_drop;
    logic          w_push;
    logic          w_q_empty;
    logic          w_drain;
    logic          w_mis_write;
    logic [CW-1:0] w_out_next;

    function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
        return (p == AW'(MAX_OUTSTANDING - 1)) ? '0 : p + AW'(1);
    endfunction

    // Requests plus buffered responses never exceed the queue depth, so a
    // response can always be accepted even while the FIFO is full.
    assign w_in_flight = {1'b0, r_outstanding} + {1'b0, r_q_cnt};
    assign w_req       = !rst && (r_state == ST_RUN) && (r_pc[1:0] == 2'b00) &&
                         !redirect_valid && (r_drop_cnt == '0) &&
                         (w_in_flight < (CW + 1)'(MAX_OUTSTANDING));
    assign w_accept    = w_req && icache_addr_ok;
    assign w_rsp_keep  = icache_rvalid && (r_drop_cnt == '0);
    assign w_rsp_drop  = icache_rvalid && (r_drop_cnt != '0);
    assign w_push      = w_rsp_keep && !redirect_valid;
    assign w_q_empty   = (r_q_cnt == '0);
    assign w_drain     = !w_q_empty && !fifo_full && !redirect_valid;
    assign w_out_next  = r_outstanding + CW'(w_accept) - CW'(icache_rvalid);

    // The misaligned-PC pseudo instruction goes out only once the pipe is empty
    assign w_mis_write = (r_state == ST_RUN) && (r_pc[1:0] != 2'b00) &&
                         (r_outstanding == '0) && w_q_empty &&
                         !fifo_full && !redirect_valid;

    assign icache_req  = w_req;
    assign icache_addr = {r_pc[31:3], 3'b000};

    // Fetch PC, run/halt state, in-flight and stale-response accounting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect_valid) begin
                r_pc       <= redirect_pc;
                r_state    <= ST_RUN;
                // Everything still in flight after this cycle is stale; a
                // response on the bus this cycle is gone either way.
                r_drop_cnt <= w_out_next;
            end else begin
                if (w_rsp_drop) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
                if (w_accept) begin
                    r_pc <= r_pc + (r_pc[2] ? 32'd4 : 32'd8);
                end
                if (w_mis_write) begin
                    r_state <= ST_HALT;
                end
            end
        end
    end

    // Request-kind FIFO pointers; entries retire with every response, stale or not
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rk_wr <= '0;
            r_rk_rd <= '0;
        end else begin
            if (w_accept) begin
                r_rk_wr <= f_next(r_rk_wr);
            end
            if (icache_rvalid) begin
                r_rk_rd <= f_next(r_rk_rd);
            end
        end
    end

    // Response queue pointers and occupancy; a redirect empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_wr  <= '0;
            r_q_rd  <= '0;
            r_q_cnt <= '0;
        end else if (redirect_valid) begin
            r_q_wr  <= '0;
            r_q_rd  <= '0;
            r_q_cnt <= '0;
        end else begin
            if (w_push) begin
                r_q_wr <= f_next(r_q_wr);
            end
            if (w_drain) begin
                r_q_rd <= f_next(r_q_rd);
            end
            r_q_cnt <= r_q_cnt + CW'(w_push) - CW'(w_drain);
        end
    end

    // Slot storage; only pointers need reset, data is qualified by them
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rk_pc[r_rk_wr]   <= r_pc;
            r_rk_pair[r_rk_wr] <= ~r_pc[2];
        end
        if (w_push) begin
            r_q_pc[r_q_wr]    <= r_rk_pc[r_rk_rd];
            r_q_inst1[r_q_wr] <= r_rk_pair[r_rk_rd] ? icache_rdata[31:0] : icache_rdata[63:32];
            r_q_inst2[r_q_wr] <= icache_rdata[63:32];
            r_q_err[r_q_wr]   <= icache_rerr;
            r_q_pair[r_q_wr]  <= r_rk_pair[r_rk_rd];
        end
    end

    // FIFO write port driven straight from the queue head (or the misaligned marker)
    always_comb begin
        write_en_1      = 1'b0;
        write_en_2      = 1'b0;
        write_inst1     = '0;
        write_inst2     = '0;
        write_pc1       = '0;
        write_pc2       = '0;
        write_inst_exp1 = '0;
        if (w_drain) begin
            write_en_1         = 1'b1;
            write_inst1        = r_q_inst1[r_q_rd];
            write_pc1          = r_q_pc[r_q_rd];
            write_inst_exp1[1] = r_q_err[r_q_rd];
            if (r_q_pair[r_q_rd]) begin
                write_en_2  = 1'b1;
                write_inst2 = r_q_inst2[r_q_rd];
                write_pc2   = r_q_pc[r_q_rd] + 32'd4;
            end
        end else if (w_mis_write) begin
            write_en_1         = 1'b1;
            write_pc1          = r_pc;
            write_inst_exp1[0] = 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Instructions delivered and cycles lost to back-pressure; both wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_inst_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (write_en_1) begin
                perf_inst_cnt <= perf_inst_cnt + (write_en_2 ? 32'd2 : 32'd1);
            end
            if (!w_q_empty && fifo_full) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: in-order I-cache model plus write scoreboard for
// inst_fetch_unit. Expected FIFO writes are queued when the cache model returns
// a response for the current fetch epoch and checked when the DUT writes.
module tb_inst_fetch_unit;

    localparam int          MAXO   = 2;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fifo_full;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_addr_ok;
    logic        icache_rvalid;
    logic [63:0] icache_rdata;
    logic        icache_rerr;
    logic        write_en_1;
    logic        write_en_2;
    logic [31:0] write_inst1;
    logic [31:0] write_inst2;
    logic [31:0] write_pc1;
    logic [31:0] write_pc2;
    logic [13:0] write_inst_exp1;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_inst_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    inst_fetch_unit #(.MAX_OUTSTANDING(MAXO), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fifo_full      (fifo_full),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_addr_ok (icache_addr_ok),
        .icache_rvalid  (icache_rvalid),
        .icache_rdata   (icache_rdata),
        .icache_rerr    (icache_rerr),
        .write_en_1     (write_en_1),
        .write_en_2     (write_en_2),
        .write_inst1    (write_inst1),
        .write_inst2    (write_inst2),
        .write_pc1      (write_pc1),
        .write_pc2      (write_pc2),
        .write_inst_exp1(write_inst_exp1)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_inst_cnt  (perf_inst_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int unsigned epoch;
        bit          err;
    } req_t;

    typedef struct {
        logic [31:0] pc1;
        logic [31:0] inst1;
        bit          en2;
        logic [31:0] pc2;
        logic [31:0] inst2;
        logic [13:0] exp;
    } wr_t;

    typedef struct {
        logic [31:0] rpc;
        bit          err;
        int          full_cyc;
        int          run_cyc;
        logic [31:0] x_pc1;
        bit          x_en2;
        logic [13:0] x_exp;
        logic [31:0] x_inst;
        bit          has2;
        logic [31:0] x_pc2nd;
    } vec_t;

    req_t        inflight[$];
    wr_t         sb[$];
    wr_t         wlog[$];
    logic [31:0] acc_log[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_insts  = 0;
    int unsigned epoch    = 0;
    logic [31:0] fetch_pc;
    bit          halted;
    bit          cache_stall;
    bit          cur_err;
    bit          last_req;

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic int stale_count();
        int n = 0;
        foreach (inflight[i]) if (inflight[i].epoch != epoch) n++;
        return n;
    endfunction

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One clock cycle: drive cache response, sample/compare outputs, update models
    task automatic cycle();
        bit   rv;
        bit   acc;
        bit   ok;
        req_t h;
        wr_t  w;
        wr_t  a;
        rv = (inflight.size() > 0) && !cache_stall;
        icache_rvalid = rv;
        if (rv) begin
            h = inflight[0];
            icache_rdata = {f({h.pc[31:3], 3'b000} + 32'd4), f({h.pc[31:3], 3'b000})};
            icache_rerr  = h.err;
        end else begin
            icache_rdata = '0;
            icache_rerr  = 1'b0;
        end
        #1;
        last_req = icache_req;
        if (redirect_valid)
            check(!icache_req && !write_en_1, "redirect_cycle_quiet", {icache_req, write_en_1}, 0);
        if (fifo_full)
            check(!write_en_1, "no_write_while_full", write_en_1, 0);
        if (stale_count() > 0 || halted)
            check(!icache_req, "req_blocked", icache_req, 0);
        acc = icache_req && icache_addr_ok;
        if (acc) begin
            check(inflight.size() < MAXO, "outstanding_cap", inflight.size(), MAXO - 1);
            check(icache_addr == {fetch_pc[31:3], 3'b000}, "req_addr", icache_addr, {fetch_pc[31:3], 3'b000});
        end
        if (write_en_1 || write_en_2) begin
            a = '{write_pc1, write_inst1, write_en_2, write_pc2, write_inst2, write_inst_exp1};
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_write", write_pc1, 0);
            end else begin
                w = sb.pop_front();
                ok = write_en_1 && (write_pc1 == w.pc1) && (write_inst1 == w.inst1) &&
                     (write_en_2 == w.en2) && (write_inst_exp1 == w.exp) &&
                     (!w.en2 || ((write_pc2 == w.pc2) && (write_inst2 == w.inst2)));
                n_checks++;
                if (!ok) begin
                    n_errors++;
                    $display("FAIL write: got en=%b%b pc1=%h inst1=%h pc2=%h inst2=%h exp=%h, expected en=1%b pc1=%h inst1=%h pc2=%h inst2=%h exp=%h",
                             write_en_1, write_en_2, write_pc1, write_inst1, write_pc2, write_inst2, write_inst_exp1,
                             w.en2, w.pc1, w.inst1, w.pc2, w.inst2, w.exp);
                end
            end
            wlog.push_back(a);
            n_insts += write_en_2 ? 2 : 1;
        end
        @(posedge clk);
        if (rv) begin
            h = inflight.pop_front();
            if (h.epoch == epoch && !redirect_valid)
                sb.push_back('{h.pc, f(h.pc), !h.pc[2], h.pc + 32'd4, f(h.pc + 32'd4),
                               h.err ? 14'h0002 : 14'h0000});
        end
        if (redirect_valid) begin
            epoch++;
            sb.delete();
            fetch_pc = redirect_pc;
            halted   = (redirect_pc[1:0] != 2'b00);
            if (halted)
                sb.push_back('{redirect_pc, 32'h0, 1'b0, 32'h0, 32'h0, 14'h0001});
        end else if (acc) begin
            inflight.push_back('{fetch_pc, epoch, cur_err});
            acc_log.push_back(icache_addr);
            fetch_pc = fetch_pc + (fetch_pc[2] ? 32'd4 : 32'd8);
        end
        @(negedge clk);
    endtask

    task automatic fill_two();
        cache_stall = 1'b1;
        for (int i = 0; i < 10 && inflight.size() < 2; i++) cycle();
        check(inflight.size() == 2, "two_outstanding_reached", inflight.size(), 2);
    endtask

    initial begin
        vec_t tbl[6];
        int   base;
        wr_t  w;
        bit   ok;

        tbl[0] = '{32'h8000_0004, 1'b0, 0, 8,  32'h8000_0004, 1'b0, 14'h0000, f(32'h8000_0004), 1'b1, 32'h8000_0008};
        tbl[1] = '{32'h8000_0002, 1'b0, 3, 10, 32'h8000_0002, 1'b0, 14'h0001, 32'h0,            1'b0, 32'h0};
        tbl[2] = '{32'h8000_0200, 1'b1, 0, 8,  32'h8000_0200, 1'b1, 14'h0002, f(32'h8000_0200), 1'b1, 32'h8000_0208};
        tbl[3] = '{32'hFFFF_FFF8, 1'b0, 2, 10, 32'hFFFF_FFF8, 1'b1, 14'h0000, f(32'hFFFF_FFF8), 1'b1, 32'h0000_0000};
        tbl[4] = '{32'h0000_000C, 1'b0, 0, 8,  32'h0000_000C, 1'b0, 14'h0000, f(32'h0000_000C), 1'b1, 32'h0000_0010};
        tbl[5] = '{32'h8000_0100, 1'b0, 4, 10, 32'h8000_0100, 1'b1, 14'h0000, f(32'h8000_0100), 1'b1, 32'h8000_0108};

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; fifo_full = 1'b0;
        icache_addr_ok = 1'b1; icache_rvalid = 1'b0; icache_rdata = '0; icache_rerr = 1'b0;
        cache_stall = 1'b0; cur_err = 1'b0; halted = 1'b0; fetch_pc = RST_PC;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check(!icache_req && !write_en_1 && !write_en_2, "reset_outputs", {icache_req, write_en_1, write_en_2}, 0);
        check(write_inst_exp1 == 14'h0, "reset_exp", write_inst_exp1, 0);
        @(negedge clk);
        rst = 1'b0;

        // Boot fetch: pairs from RESET_PC
        wlog.delete(); acc_log.delete();
        repeat (8) cycle();
        if (acc_log.size() == 0) check(1'b0, "boot_first_req", 0, RST_PC);
        else check(acc_log[0] == RST_PC, "boot_first_req", acc_log[0], RST_PC);
        if (wlog.size() < 2) check(1'b0, "boot_two_pairs", wlog.size(), 2);
        else check(wlog[0].pc1 == RST_PC && wlog[0].en2 && wlog[1].pc1 == RST_PC + 32'd8 && wlog[1].en2,
                   "boot_two_pairs", {wlog[0].pc1, wlog[1].pc1}, {RST_PC, RST_PC + 32'd8});

        // Two outstanding, then redirect: both stale responses dropped
        fill_two();
        cycle();
        check(!last_req, "req_stops_at_max_outstanding", last_req, 0);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
        cycle();
        redirect_valid = 1'b0; cache_stall = 1'b0;
        wlog.delete();
        repeat (10) cycle();
        if (wlog.size() == 0) check(1'b0, "drop_first_write", 0, 32'h8000_1000);
        else check(wlog[0].pc1 == 32'h8000_1000, "drop_first_write", wlog[0].pc1, 32'h8000_1000);

        // FIFO full for 10 cycles: queue fills, issue stops, nothing lost
        fifo_full = 1'b1;
        repeat (10) cycle();
        check(!last_req, "req_stops_when_queue_full", last_req, 0);
        check(inflight.size() == 0, "nothing_in_flight_when_full", inflight.size(), 0);
        fifo_full = 1'b0;
        base = n_insts;
        repeat (2) cycle();
        check(n_insts - base == 4, "release_writes_four", n_insts - base, 4);

        // Back-to-back redirects with a stale response in the second cycle
        fill_two();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
        cycle();
        cache_stall = 1'b0; redirect_pc = 32'h8000_3000;
        cycle();
        redirect_valid = 1'b0;
        wlog.delete();
        repeat (12) cycle();
        if (wlog.size() < 2) check(1'b0, "b2b_redirect_stream", wlog.size(), 2);
        else check(wlog[0].pc1 == 32'h8000_3000 && wlog[1].pc1 == 32'h8000_3008, "b2b_redirect_stream",
                   {wlog[0].pc1, wlog[1].pc1}, {32'h8000_3000, 32'h8000_3008});

        // Table of redirect scenarios
        for (int t = 0; t < 6; t++) begin
            cur_err = tbl[t].err;
            wlog.delete();
            redirect_valid = 1'b1; redirect_pc = tbl[t].rpc;
            cycle();
            redirect_valid = 1'b0; redirect_pc = '0;
            fifo_full = 1'b1;
            repeat (tbl[t].full_cyc) cycle();
            fifo_full = 1'b0;
            repeat (tbl[t].run_cyc) cycle();
            if (wlog.size() == 0) begin
                check(1'b0, "vec_first_write_missing", t, 1);
            end else begin
                w = wlog[0];
                ok = (w.pc1 == tbl[t].x_pc1) && (w.en2 == tbl[t].x_en2) &&
                     (w.exp == tbl[t].x_exp) && (w.inst1 == tbl[t].x_inst);
                n_checks++;
                if (!ok) begin
                    n_errors++;
                    $display("FAIL vec%0d_first_write: got pc1=%h en2=%b exp=%h inst1=%h, expected pc1=%h en2=%b exp=%h inst1=%h",
                             t, w.pc1, w.en2, w.exp, w.inst1, tbl[t].x_pc1, tbl[t].x_en2, tbl[t].x_exp, tbl[t].x_inst);
                end
                if (!tbl[t].has2)
                    check(wlog.size() == 1, "vec_halt_single_write", wlog.size(), 1);
                else if (wlog.size() < 2)
                    check(1'b0, "vec_second_write", wlog.size(), 2);
                else
                    check(wlog[1].pc1 == tbl[t].x_pc2nd, "vec_second_write", wlog[1].pc1, tbl[t].x_pc2nd);
            end
        end
        cur_err = 1'b0;

        // Asynchronous reset in the middle of a burst
        fill_two();
        #2;
        rst = 1'b1;
        #1;
        check(!icache_req && !write_en_1, "async_reset_outputs", {icache_req, write_en_1}, 0);
        check(icache_addr == RST_PC, "async_reset_pc", icache_addr, RST_PC);
        inflight.delete(); sb.delete();
        icache_rvalid = 1'b0; cache_stall = 1'b0; halted = 1'b0;
        epoch++; fetch_pc = RST_PC; n_insts = 0;
        @(negedge clk);
        rst = 1'b0;
        wlog.delete();
        repeat (8) cycle();
        if (wlog.size() == 0) check(1'b0, "post_reset_first_write", 0, RST_PC);
        else check(wlog[0].pc1 == RST_PC, "post_reset_first_write", wlog[0].pc1, RST_PC);
`ifdef FETCH_PERF_CNT_EN
        check(perf_inst_cnt == n_insts, "perf_inst_cnt", perf_inst_cnt, n_insts);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
